// File: rtl/cpu_bus_bridge_pkg.sv
// Shared types and constants for the CPU-to-bus bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_bus_bridge_pkg;

    // Bridge transaction state: idle, address phase, data phase
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Channel select encoding; a future third channel would widen this
    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/cpu_bus_bridge_arbiter.sv
// Pending/priority select between the fetch and load/store channels.
// Latency: purely combinational.
// Backpressure: a channel whose done flag is set is no longer pending.
module bridge_arbiter
    import cpu_bus_bridge_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic inst_req,
    input  logic inst_done,
    input  logic data_req,
    input  logic data_done,
    output logic any_pend,
    output logic sel
);

    logic inst_pend;
    logic data_pend;

    // Fixed-priority pick among channels still waiting for a result
    always_comb begin
        inst_pend = inst_req & ~inst_done;
        data_pend = data_req & ~data_done;
        any_pend  = inst_pend | data_pend;
        if (inst_pend && data_pend) begin
            sel = DATA_FIRST ? SEL_DATA : SEL_INST;
        end else begin
            sel = data_pend ? SEL_DATA : SEL_INST;
        end
    end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Merges fetch and load/store channels onto one req/addr_ok/data_ok bus; optional BRIDGE_PERF_CNT_EN adds counters.
// Latency: bus_req in the first request cycle; result registered, stall drops the cycle after data_ok.
// Backpressure: mem_stall holds the pipeline until every live request has its result; addr held until addr_ok.
module cpu_bus_bridge
    import cpu_bus_bridge_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_stall,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
`ifdef BRIDGE_PERF_CNT_EN
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_bus_xfers,
`endif
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state;
    state_t              state_nxt;
    logic                inst_done;
    logic                data_done;
    logic                any_pend;
    logic                sel_arb;
    logic                sel_q;
    logic                wr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                launch;
    logic                xfer_done;

    bridge_arbiter #(.DATA_FIRST(DATA_FIRST)) u_arb (
        .inst_req  (inst_req),
        .inst_done (inst_done),
        .data_req  (data_req),
        .data_done (data_done),
        .any_pend  (any_pend),
        .sel       (sel_arb)
    );

    assign mem_stall = (inst_req & ~inst_done) | (data_req & ~data_done);
    assign launch    = (state == IDLE) && any_pend;
    assign xfer_done = (state == WAIT) && bus_data_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus drive; IDLE issues straight from the channel inputs so no cycle is lost
    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    bus_req = 1'b1;
                    if (sel_arb == SEL_DATA) begin
                        bus_wr    = |data_wen;
                        bus_wstrb = data_wen;
                        bus_addr  = data_addr;
                        bus_wdata = data_wdata;
                    end else begin
                        bus_addr  = inst_addr;
                    end
                    state_nxt = bus_addr_ok ? WAIT : ADDR;
                end
            end
            ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = wr_q;
                bus_wstrb = wstrb_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                if (bus_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the issued command so it stays stable even if the requester misbehaves
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= SEL_INST;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (launch) begin
            sel_q   <= sel_arb;
            wr_q    <= bus_wr;
            wstrb_q <= bus_wstrb;
            addr_q  <= bus_addr;
            wdata_q <= bus_wdata;
        end
    end

    // Capture read data for the owning channel; writes leave data_rdata alone
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else if (xfer_done) begin
            if (sel_q == SEL_INST) begin
                inst_rdata <= bus_rdata;
            end else if (!wr_q) begin
                data_rdata <= bus_rdata;
            end
        end
    end

    // Done flags: clearing on pipeline advance wins, so a result for a dropped request is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else if (!mem_stall) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else if (xfer_done) begin
            if (sel_q == SEL_INST) begin
                inst_done <= 1'b1;
            end else begin
                data_done <= 1'b1;
            end
        end
    end

`ifdef BRIDGE_PERF_CNT_EN
    // Free-running stall and transfer counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_bus_xfers    <= '0;
        end else begin
            if (mem_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (bus_data_ok) begin
                perf_bus_xfers <= perf_bus_xfers + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: two instances (data-first and fetch-first) each with a small slave.
// Latency: slave gives addr_ok after addr_delay cycles of bus_req, data_ok one cycle after acceptance.
// Backpressure: requests are held by the bench while mem_stall is high.
module tb_cpu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    int          addr_delay = 0;
    logic        log_clr = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] resp(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: resp = 32'h3C08_0001;
            32'h8000_0020: resp = 32'h1234_5678;
            default:       resp = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata, bus_rdata, paddr;
        logic        mem_stall, bus_req, bus_wr, bus_addr_ok, bus_data_ok, pend;
        logic [3:0]  bus_wstrb;
        int          wait_cnt;
        int          log_n;
        logic [31:0] log_addr [4];
        logic        log_wr [4];
`ifdef BRIDGE_PERF_CNT_EN
        logic [31:0] perf_stall_cycles, perf_bus_xfers;
`endif

        cpu_bus_bridge #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .DATA_FIRST ((g == 0) ? 1'b1 : 1'b0)
        ) dut (
            .clk               (clk),
            .rst               (rst),
            .inst_req          (inst_req),
            .inst_addr         (inst_addr),
            .inst_rdata        (inst_rdata),
            .data_req          (data_req),
            .data_wen          (data_wen),
            .data_addr         (data_addr),
            .data_wdata        (data_wdata),
            .data_rdata        (data_rdata),
            .mem_stall         (mem_stall),
            .bus_req           (bus_req),
            .bus_wr            (bus_wr),
            .bus_wstrb         (bus_wstrb),
            .bus_addr          (bus_addr),
            .bus_wdata         (bus_wdata),
            .bus_addr_ok       (bus_addr_ok),
            .bus_data_ok       (bus_data_ok),
`ifdef BRIDGE_PERF_CNT_EN
            .perf_stall_cycles (perf_stall_cycles),
            .perf_bus_xfers    (perf_bus_xfers),
`endif
            .bus_rdata         (bus_rdata)
        );

        assign bus_addr_ok = bus_req && (wait_cnt >= addr_delay);
        assign bus_data_ok = pend;
        assign bus_rdata   = pend ? resp(paddr) : 32'h0;

        // Slave model plus a log of accepted commands
        always @(posedge clk) begin
            if (rst) begin
                wait_cnt <= 0;
                pend     <= 1'b0;
                paddr    <= '0;
            end else begin
                wait_cnt <= (bus_req && !bus_addr_ok) ? wait_cnt + 1 : 0;
                pend     <= bus_req && bus_addr_ok;
                if (bus_req && bus_addr_ok) paddr <= bus_addr;
            end
            if (log_clr) begin
                log_n <= 0;
            end else if (!rst && bus_req && bus_addr_ok && log_n < 4) begin
                log_addr[log_n] <= bus_addr;
                log_wr[log_n]   <= bus_wr;
                log_n           <= log_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Count stall cycles from the current cycle until both instances release the pipeline
    task automatic wait_idle(output int s0, output int s1);
        bit fin;
        fin = 1'b0;
        s0 = 0;
        s1 = 0;
        for (int c = 0; c < 30 && !fin; c++) begin
            if (g_inst[0].mem_stall) s0++;
            if (g_inst[1].mem_stall) s1++;
            if (!g_inst[0].mem_stall && !g_inst[1].mem_stall) begin
                fin = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!fin) check("stall_timeout", 32'({g_inst[1].mem_stall, g_inst[0].mem_stall}), 32'h0);
    endtask

    task automatic clear_log();
        inst_req = 1'b0;
        data_req = 1'b0;
        data_wen = '0;
        log_clr  = 1'b1;
        @(negedge clk);
        log_clr  = 1'b0;
    endtask

    initial begin
        int s0, s1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bus_req",    32'(g_inst[0].bus_req), 32'h0);
        check("rst_mem_stall",  32'(g_inst[0].mem_stall), 32'h0);
        check("rst_inst_rdata", g_inst[0].inst_rdata, 32'h0);
        check("rst_data_rdata", g_inst[0].data_rdata, 32'h0);

        // Fetch and store together: instance 0 is data-first, instance 1 fetch-first
        clear_log();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        #1;
        check("s2_stall_first",  32'(g_inst[0].mem_stall), 32'h1);
        check("s2_wr",           32'(g_inst[0].bus_wr), 32'h1);
        check("s2_wstrb",        32'(g_inst[0].bus_wstrb), 32'hF);
        check("s2_wdata",        g_inst[0].bus_wdata, 32'hDEAD_BEEF);
        check("s3_first_addr",   g_inst[1].bus_addr, 32'hBFC0_0000);
        check("s3_first_wr",     32'(g_inst[1].bus_wr), 32'h0);
        wait_idle(s0, s1);
        check("s2_stall_cycles", 32'(s0), 32'd4);
        check("s3_stall_cycles", 32'(s1), 32'd4);
        check("s2_log0_addr",    g_inst[0].log_addr[0], 32'h8000_0010);
        check("s2_log0_wr",      32'(g_inst[0].log_wr[0]), 32'h1);
        check("s2_log1_addr",    g_inst[0].log_addr[1], 32'hBFC0_0000);
        check("s2_log1_wr",      32'(g_inst[0].log_wr[1]), 32'h0);
        check("s3_log0_addr",    g_inst[1].log_addr[0], 32'hBFC0_0000);
        check("s3_log1_addr",    g_inst[1].log_addr[1], 32'h8000_0010);
        check("s3_log1_wr",      32'(g_inst[1].log_wr[1]), 32'h1);
        check("s2_inst_rdata",   g_inst[0].inst_rdata, 32'h3C08_0001);
        check("s2_data_rdata",   g_inst[0].data_rdata, 32'h0);
`ifdef BRIDGE_PERF_CNT_EN
        check("perf_xfers",      g_inst[0].perf_bus_xfers, 32'd2);
        check("perf_stall",      g_inst[0].perf_stall_cycles, 32'(s0));
`endif

        // Fetch only, immediate addr_ok
        clear_log();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1;
        check("s1_req",          32'(g_inst[0].bus_req), 32'h1);
        check("s1_wr",           32'(g_inst[0].bus_wr), 32'h0);
        check("s1_addr",         g_inst[0].bus_addr, 32'hBFC0_0000);
        @(negedge clk); #1;
        check("s1_req_gone",     32'(g_inst[0].bus_req), 32'h0);
        wait_idle(s0, s1);
        check("s1_stall_cycles", 32'(s0 + 1), 32'd2);
        check("s1_inst_rdata",   g_inst[0].inst_rdata, 32'h3C08_0001);

        // Load with addr_ok delayed by 3 cycles
        clear_log();
        addr_delay = 3;
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_0020;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("s4_req_held",  32'(g_inst[0].bus_req), 32'h1);
            check("s4_addr_held", g_inst[0].bus_addr, 32'h8000_0020);
            check("s4_rdata_old", g_inst[0].data_rdata, 32'h0);
            @(negedge clk);
        end
        #1;
        check("s4_data_ok",      32'(g_inst[0].bus_data_ok), 32'h1);
        check("s4_rdata_before", g_inst[0].data_rdata, 32'h0);
        wait_idle(s0, s1);
        check("s4_stall_cycles", 32'(s0 + 4), 32'd5);
        check("s4_data_rdata",   g_inst[0].data_rdata, 32'h1234_5678);
        addr_delay = 0;

        // Reset while the transaction waits for data
        clear_log();
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_0040;
        @(negedge clk); #1;
        check("s5_in_wait",      32'(g_inst[0].bus_req), 32'h0);
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk); #1;
        check("s5_bus_req",      32'(g_inst[0].bus_req), 32'h0);
        check("s5_stall",        32'(g_inst[0].mem_stall), 32'h0);
        check("s5_data_rdata",   g_inst[0].data_rdata, 32'h0);
        check("s5_inst_rdata",   g_inst[0].inst_rdata, 32'h0);
`ifdef BRIDGE_PERF_CNT_EN
        check("s5_perf_xfers",   g_inst[0].perf_bus_xfers, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        #1;
        check("s5_fresh_stall",  32'(g_inst[0].mem_stall), 32'h1);
        check("s5_fresh_req",    32'(g_inst[0].bus_req), 32'h1);
        wait_idle(s0, s1);
        check("s5_fresh_cycles", 32'(s0), 32'd2);
        check("s5_fresh_rdata",  g_inst[0].inst_rdata, 32'h1A65_A5A1);
        clear_log();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Joins the core's two blocking memory channels (instruction fetch, data load/store) onto one SRAM-like split-transaction bus (req/addr_ok/data_ok).
- Arbitrates between the channels and generates `mem_stall` back to the pipeline.
- Parametrised successor of the fixed 32-bit single-cycle memory hookup; sits between the core top and the external memory/cache port.

Parameters:
- ADDR_W, 32, address width of both channels and the bus
- DATA_W, 32, data width; must be a multiple of 8; strobe width is DATA_W/8
- DATA_FIRST, 1, 1: data channel wins when both request; 0: instruction channel wins

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held stable while mem_stall=1
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word (registered)
- data_req  in  1  load/store request; held stable while mem_stall=1
- data_wen  in  DATA_W/8  byte write strobes; all-zero means load
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load result (registered)
- mem_stall  out  1  pipeline must hold all stages
- bus_req  out  1  bus request
- bus_wr  out  1  1 = write
- bus_wstrb  out  DATA_W/8  byte strobes (zero on reads)
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  address accepted this cycle
- bus_data_ok  in  1  read data valid / write complete this cycle
- bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset: state=IDLE; inst_done=data_done=0; inst_rdata=data_rdata=0; bus_req=0.
  - Reset mid-transaction abandons it; the slave is reset by the same rst.
- Done flags:
  - `inst_done`/`data_done` set on bus_data_ok of that channel's transaction.
  - Both flags clear in any cycle where mem_stall=0 (pipeline advances).
- mem_stall = (inst_req & ~inst_done) | (data_req & ~data_done); combinational, so it asserts in the first request cycle.
- FSM has one outstanding transaction at most.
  - IDLE: if a pending channel exists, select it (DATA_FIRST picks on tie) and go to ADDR. bus_req is driven in the same cycle.
  - ADDR: bus_req=1 with the selected channel's addr/wr/wstrb/wdata, held stable. On bus_addr_ok go to WAIT.
  - WAIT: bus_req=0. On bus_data_ok: capture bus_rdata into the channel's rdata (reads only; writes leave data_rdata unchanged), set its done flag, go to IDLE.
- IDLE may launch directly to ADDR in the same cycle, so back-to-back channels lose no idle cycle. Minimum single-access stall is 2 cycles (addr_ok in cycle 0, data_ok in cycle 1, stall low in cycle 2).
- bus_wr = |data_wen for data transactions; always 0 for instruction transactions.
- Latched selection is not re-arbitrated until WAIT completes.
- Request dropped while in ADDR (illegal per hold rule): the transaction still completes and its result is discarded at the next clear.
- Simultaneous bus_addr_ok and bus_data_ok in ADDR: ignore data_ok; the slave must not do this.
- rdata outputs hold their last value until overwritten.

Optional Feature:
- Macro BRIDGE_PERF_CNT_EN.
- Defined: adds outputs `perf_stall_cycles` [31:0] and `perf_bus_xfers` [31:0].
  - perf_stall_cycles increments each cycle mem_stall=1.
  - perf_bus_xfers increments on each bus_data_ok.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ADDR, WAIT)
  - channel-select constants (SEL_INST=0, SEL_DATA=1)
  - default widths
- One natural sub-module: bridge_arbiter. Combinational pending/priority select from req, done flags and DATA_FIRST; reusable for a future third channel.

Test Plan:
1. Fetch only, inst_addr=0xBFC00000, slave addr_ok immediately, data_ok 1 cycle later with 0x3C080001 -> bus_req for 1 cycle with bus_wr=0; inst_rdata=0x3C080001; mem_stall high exactly 2 cycles.
2. Fetch and store same cycle (data_wen=4'b1111, addr 0x80000010, wdata 0xDEADBEEF), DATA_FIRST=1 -> write issued first with bus_wstrb=4'hF, fetch issued next; stall drops one cycle after the second data_ok.
3. Same as 2 with DATA_FIRST=0 -> fetch issued before store.
4. Slave delays addr_ok by 3 cycles on a load from 0x80000020 -> bus_addr and bus_req held stable all 4 cycles; data_rdata updates only on data_ok.
5. Assert rst while in WAIT -> next cycle bus_req=0, mem_stall reflects fresh requests only, rdata=0.
6. With BRIDGE_PERF_CNT_EN, run scenario 2 -> perf_bus_xfers=2, perf_stall_cycles equals the observed stall cycle count.
